axis_crc_append: RTL and testbench
==================================

AXIS_CRC_APPEND -- requirements
Module: axis_crc_append

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, input/output beat width; any value other than 32 SHALL stop elaboration with an error.
REQ-002 SHALL have parameter MAX_LEN, default 256, maximum payload beats per packet; it is used only when AXIS_CRC_APPEND_LEN_LIMIT_EN is defined.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports s_valid (input, 1), s_ready (output, 1), s_last (input, 1) and s_data (input, DATA_WIDTH): the upstream AXIS packet stream from the source mux.
REQ-006 SHALL have ports m_valid (output, 1), m_ready (input, 1), m_last (output, 1) and m_data (output, DATA_WIDTH): the downstream stream, i.e. payload followed by one CRC beat.
REQ-007 SHALL have port trunc, output, 1 bit: one-cycle pulse when a packet is truncated.

Function
REQ-008 SHALL append one 32-bit CRC beat after each packet's last payload beat.
- CRC SHALL be CRC-32/Ethernet: poly 0x04C11DB7, init 0xFFFFFFFF, reflected in/out, final XOR 0xFFFFFFFF.
- Byte order per beat SHALL be s_data[7:0] first.
REQ-009 SHALL register the output: one output register, m_* driven only from flops, latency 1 cycle from input handshake to m_valid.
REQ-010 SHALL define a handshake as valid && ready on the same edge; once m_valid is high, m_data and m_last SHALL stay stable until m_ready.
REQ-011 SHALL load the output register only when it is free, i.e. !m_valid || m_ready.
REQ-012 SHALL implement the FSM states:
- PASS: s_ready = register free. Each accepted beat SHALL be forwarded with m_last=0 and the running CRC updated. An accepted beat with s_last=1 SHALL go to CRC.
- CRC: s_ready=0. When the register is free, it SHALL load the final CRC with m_last=1, reinitialise the running CRC, and return to PASS.
REQ-013 SHALL sustain throughput of N+1 cycles per N-beat packet with m_ready held high, with no idle cycle between packets.
REQ-014 SHALL treat a one-beat packet (s_last on the first beat) normally: 1 payload beat + 1 CRC beat.
REQ-015 SHALL NOT change state, CRC or output register while m_valid=1 and m_ready=0 (backpressure), and SHALL NOT drop or duplicate a beat.
REQ-016 SHALL keep trunc at 0 when AXIS_CRC_APPEND_LEN_LIMIT_EN is undefined.

Reset
REQ-017 SHALL, on rst low (async assert), force:
- m_valid=0, m_last=0, m_data=0, trunc=0;
- state PASS, running CRC 0xFFFFFFFF, beat counter 0.
REQ-018 SHALL release reset synchronously, with s_ready=1 on the first cycle after release.
REQ-019 SHALL discard a packet in flight at reset; no partial CRC beat is emitted afterwards.

Configuration
REQ-020 SHALL, with AXIS_CRC_APPEND_LEN_LIMIT_EN defined, enforce the length limit:
- A beat counter SHALL count the accepted payload beats of the current packet.
- When the MAX_LEN-th beat is accepted without s_last, it SHALL be forwarded, trunc SHALL pulse on the following cycle, and the FSM SHALL enter DROP.
- DROP: s_ready=1; beats are discarded until a beat with s_last is accepted, then go to CRC.
- A packet of exactly MAX_LEN beats ending in s_last SHALL NOT truncate.
REQ-021 SHALL, with the macro undefined, omit the counter and DROP state and accept unbounded packets.

Structure
REQ-022 SHALL place in shared package axis_crc_pkg:
- CRC constants (poly, init, xorout);
- the FSM state typedef (PASS, CRC, DROP).
REQ-023 SHALL use one sub-module, crc32_word: combinational next-CRC from current CRC and a 32-bit word, reflected, byte 0 first.

Verification
REQ-024 SHALL cover: 1-beat packet 0x00000000, m_ready=1 -> out 0x00000000 (last=0), then 0x2144DF1C (last=1).
REQ-025 SHALL cover: 1-beat packet 0xFFFFFFFF -> CRC beat 0xFFFFFFFF; then immediately a second 1-beat packet 0x00000000 -> CRC 0x2144DF1C (CRC reinit verified, no idle gap).
REQ-026 SHALL cover: 8-beat packet with random m_ready (50%) -> output identical to reference model, 9 beats, exactly one m_last, data stable while stalled.
REQ-027 SHALL cover: with macro defined and MAX_LEN=4, a 6-beat packet -> 4 payload beats + CRC of those 4, trunc pulses once, 2 beats dropped; a following 4-beat packet -> no trunc.
REQ-028 SHALL cover: rst low mid-packet (after beat 3 of 8) -> m_valid=0 immediately; next packet after release yields the correct CRC.

Source files
------------

// File: rtl/axis_crc_pkg.sv
// Shared constants and FSM state type for the AXIS CRC-32 append block.
// Used by axis_crc_append and crc32_word.
package axis_crc_pkg;

    // CRC-32/Ethernet parameters (normal-form polynomial).
    localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

    // Bit-reverse a 32-bit word. The CRC register shifts LSB-first, so it
    // needs the polynomial in reflected form.
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        r = {<<{v}};
        return r;
    endfunction

    localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

    // Packet FSM states. DROP is only reached when the length limit is enabled.
    typedef enum logic [1:0] {
        PASS = 2'd0,
        CRC  = 2'd1,
        DROP = 2'd2
    } state_e;

endpackage

// File: rtl/crc32_word.sv
// Combinational CRC-32/Ethernet update over one 32-bit word.
// Byte 0 (data_i[7:0]) enters first; the register is held in reflected form.
module crc32_word
    import axis_crc_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [31:0] data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    // In reflected form, XOR-ing the whole little-endian word up front and then
    // shifting 32 times is the same as feeding the four bytes in order.
    always_comb begin
        c = crc_i ^ data_i;
        for (int unsigned i = 0; i < 32; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/axis_crc_append.sv
// AXI-Stream pass-through that appends a CRC-32/Ethernet beat after each packet.
// The output is a single register stage, so latency is 1 cycle.
// Optional feature: define AXIS_CRC_APPEND_LEN_LIMIT_EN to cap packets at
// MAX_LEN payload beats. With the cap on, the block truncates longer packets,
// pulses trunc and discards the remaining beats up to s_last.
module axis_crc_append
    import axis_crc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LEN    = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  s_last,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  trunc
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("axis_crc_append: DATA_WIDTH must be 32");
    end

    if (MAX_LEN < 1) begin : g_bad_len
        $error("axis_crc_append: MAX_LEN must be at least 1");
    end

    state_e                state_q;
    logic [31:0]           crc_q;
    logic [31:0]           crc_d;
    logic                  m_valid_q;
    logic                  m_last_q;
    logic [DATA_WIDTH-1:0] m_data_q;
    logic                  reg_free;
    logic                  s_hs;

`ifdef AXIS_CRC_APPEND_LEN_LIMIT_EN
    localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             trunc_q;
`endif

    assign reg_free = !m_valid_q || m_ready;
    assign s_hs     = s_valid && s_ready;

    crc32_word u_crc32_word (
        .crc_i  (crc_q),
        .data_i (s_data),
        .crc_o  (crc_d)
    );

    // Upstream ready: follow the output register in PASS, close it while the
    // CRC beat is pending, and sink everything while dropping.
    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            PASS:    s_ready = reg_free;
            CRC:     s_ready = 1'b0;
`ifdef AXIS_CRC_APPEND_LEN_LIMIT_EN
            DROP:    s_ready = 1'b1;
`endif
            default: s_ready = 1'b0;
        endcase
    end

    // Packet FSM with running CRC and registered output beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= PASS;
            crc_q     <= CRC_INIT;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_data_q  <= '0;
`ifdef AXIS_CRC_APPEND_LEN_LIMIT_EN
            cnt_q     <= '0;
            trunc_q   <= 1'b0;
`endif
        end else begin
`ifdef AXIS_CRC_APPEND_LEN_LIMIT_EN
            trunc_q <= 1'b0;
`endif
            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
            case (state_q)
                PASS: begin
                    if (s_hs) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= s_data;
                        m_last_q  <= 1'b0;
                        crc_q     <= crc_d;
                        if (s_last) begin
                            state_q <= CRC;
`ifdef AXIS_CRC_APPEND_LEN_LIMIT_EN
                            cnt_q   <= '0;
                        end else if (cnt_q == LAST_CNT) begin
                            state_q <= DROP;
                            trunc_q <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
`endif
                        end
                    end
                end
                CRC: begin
                    if (reg_free) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= crc_q ^ CRC_XOROUT;
                        m_last_q  <= 1'b1;
                        crc_q     <= CRC_INIT;
                        state_q   <= PASS;
                    end
                end
`ifdef AXIS_CRC_APPEND_LEN_LIMIT_EN
                DROP: begin
                    if (s_valid && s_last) begin
                        state_q <= CRC;
                    end
                end
`endif
                default: state_q <= PASS;
            endcase
        end
    end

    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign m_data  = m_data_q;

`ifdef AXIS_CRC_APPEND_LEN_LIMIT_EN
    assign trunc = trunc_q;
`else
    assign trunc = 1'b0;
`endif

endmodule

// File: tb/tb_axis_crc_append.sv
// Self-checking bench for axis_crc_append against a byte-level CRC-32 model.
// Define AXIS_CRC_APPEND_LEN_LIMIT_EN to also exercise truncation (MAX_LEN=4).
`timescale 1ns/1ps
module tb_axis_crc_append;

`ifdef AXIS_CRC_APPEND_LEN_LIMIT_EN
    localparam int TB_MAX_LEN = 4;
    localparam bit LIMIT_EN   = 1'b1;
`else
    localparam int TB_MAX_LEN = 256;
    localparam bit LIMIT_EN   = 1'b0;
`endif

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        s_last  = 1'b0;
    logic [31:0] s_data  = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic        m_last;
    logic [31:0] m_data;
    logic        trunc;

    int          n_checks   = 0;
    int          n_errors   = 0;
    int unsigned cyc        = 0;
    bit          ready_rand = 1'b0;
    bit          valid_gaps = 1'b0;
    int          trunc_seen = 0;
    int          trunc_exp  = 0;

    logic [32:0] exp_q[$];
    logic [32:0] obs_q[$];
    int unsigned obs_cyc[$];

    axis_crc_append #(
        .DATA_WIDTH (32),
        .MAX_LEN    (TB_MAX_LEN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_last  (s_last),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .m_data  (m_data),
        .trunc   (trunc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference CRC-32/Ethernet computed byte by byte over the kept payload.
    function automatic logic [31:0] crc_ref(input logic [31:0] w[$]);
        logic [31:0] c;
        logic [31:0] word;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < w.size(); i++) begin
            word = w[i];
            for (int k = 0; k < 4; k++) begin
                b = word[8*k +: 8];
                c = c ^ {24'h0, b};
                for (int j = 0; j < 8; j++) begin
                    c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
                end
            end
        end
        return c ^ 32'hFFFFFFFF;
    endfunction

    // Downstream ready: always high or a 50% coin flip each cycle.
    initial forever begin
        @(posedge clk);
        #1;
        m_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: collect accepted beats, check stability under stall.
    initial begin
        logic        stall_prev;
        logic [32:0] stall_val;
        stall_prev = 1'b0;
        stall_val  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check_eq("stall_valid", 64'(m_valid), 64'd1);
                    check_eq("stall_hold", 64'({m_last, m_data}), 64'(stall_val));
                end
                if (m_valid && m_ready) begin
                    obs_q.push_back({m_last, m_data});
                    obs_cyc.push_back(cyc);
                end
                stall_prev = m_valid && !m_ready;
                stall_val  = {m_last, m_data};
                if (trunc) trunc_seen++;
            end
        end
    end

    task automatic send_beat(input logic [31:0] d, input logic last);
        int unsigned waited;
        waited = 0;
        if (valid_gaps) begin
            while ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                s_data  = $urandom;
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            waited++;
            if (waited > 200) begin
                check_eq("s_ready_wait", 64'(s_ready), 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Expected output: payload (capped at MAX_LEN when limited) then CRC of it.
    task automatic run_packet(input logic [31:0] w[$]);
        logic [31:0] kept[$];
        for (int i = 0; i < w.size(); i++) begin
            if (!LIMIT_EN || i < TB_MAX_LEN) kept.push_back(w[i]);
        end
        if (w.size() > kept.size()) trunc_exp++;
        for (int i = 0; i < kept.size(); i++) exp_q.push_back({1'b0, kept[i]});
        exp_q.push_back({1'b1, crc_ref(kept)});
        for (int i = 0; i < w.size(); i++) send_beat(w[i], i == w.size() - 1);
    endtask

    task automatic wait_obs(input int n);
        int unsigned t;
        t = 0;
        while (obs_q.size() < n && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (obs_q.size() < n) check_eq("obs_wait", 64'(obs_q.size()), 64'(n));
    endtask

    task automatic drain_compare(input string tag);
        int n;
        wait_obs(exp_q.size());
        repeat (4) @(posedge clk);
        #1;
        check_eq({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq({tag, "_beat"}, 64'(obs_q[i]), 64'(exp_q[i]));
        check_eq({tag, "_trunc"}, 64'(trunc_seen), 64'(trunc_exp));
        obs_q.delete();
        exp_q.delete();
        obs_cyc.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w[$];
        int          n_last;
        int          t0;

        // Reset values while held in reset, then s_ready right after release.
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_m_valid", 64'(m_valid), 64'd0);
        check_eq("rst_m_last", 64'(m_last), 64'd0);
        check_eq("rst_m_data", 64'(m_data), 64'd0);
        check_eq("rst_trunc", 64'(trunc), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rel_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;

        // One zero beat: payload then known CRC, output one cycle after accept.
        w = {32'h0000_0000};
        run_packet(w);
        check_eq("lat_m_valid", 64'(m_valid), 64'd1);
        check_eq("lat_m_data", 64'({m_last, m_data}), 64'({1'b0, 32'h0}));
        wait_obs(2);
        if (obs_q.size() >= 2) begin
            check_eq("zero_payload", 64'(obs_q[0]), 64'({1'b0, 32'h0000_0000}));
            check_eq("zero_crc", 64'(obs_q[1]), 64'({1'b1, 32'h2144_DF1C}));
        end
        drain_compare("zero");

        // Back-to-back one-beat packets: CRC reinit and no idle cycles.
        w = {32'hFFFF_FFFF};
        run_packet(w);
        w = {32'h0000_0000};
        run_packet(w);
        wait_obs(4);
        if (obs_q.size() >= 4) begin
            check_eq("ones_crc", 64'(obs_q[1]), 64'({1'b1, 32'hFFFF_FFFF}));
            check_eq("reinit_crc", 64'(obs_q[3]), 64'({1'b1, 32'h2144_DF1C}));
            check_eq("no_gap", 64'(obs_cyc[3] - obs_cyc[0]), 64'd3);
        end
        drain_compare("b2b");

`ifdef AXIS_CRC_APPEND_LEN_LIMIT_EN
        // Over-length packet truncates once; an exact-length one does not.
        t0 = trunc_seen;
        w.delete();
        for (int i = 0; i < 6; i++) w.push_back($urandom);
        run_packet(w);
        drain_compare("trunc6");
        check_eq("trunc6_pulses", 64'(trunc_seen - t0), 64'd1);
        t0 = trunc_seen;
        w.delete();
        for (int i = 0; i < 4; i++) w.push_back($urandom);
        run_packet(w);
        drain_compare("exact4");
        check_eq("exact4_pulses", 64'(trunc_seen - t0), 64'd0);
`endif

        // Eight beats with random downstream backpressure.
        ready_rand = 1'b1;
        w.delete();
        for (int i = 0; i < 8; i++) w.push_back($urandom);
        run_packet(w);
        wait_obs(exp_q.size());
        n_last = 0;
        for (int i = 0; i < obs_q.size(); i++) if (obs_q[i][32]) n_last++;
        check_eq("bp8_lasts", 64'(n_last), 64'd1);
        drain_compare("bp8");

        // Random lengths, input gaps and backpressure.
        valid_gaps = 1'b1;
        for (int p = 0; p < 12; p++) begin
            w.delete();
            for (int i = 0; i < int'($urandom_range(1, 10)); i++) w.push_back($urandom);
            run_packet(w);
        end
        drain_compare("rand");

        // Reset mid-packet after beat 3 of 8, then a clean packet.
        ready_rand = 1'b0;
        valid_gaps = 1'b0;
        for (int i = 0; i < 3; i++) send_beat($urandom, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("midrst_m_valid", 64'(m_valid), 64'd0);
        check_eq("midrst_m_data", 64'(m_data), 64'd0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        obs_q.delete();
        obs_cyc.delete();
        @(negedge clk);
        check_eq("midrst_s_ready", 64'(s_ready), 64'd1);
        @(posedge clk);
        #1;
        w.delete();
        for (int i = 0; i < 8; i++) w.push_back($urandom);
        run_packet(w);
        drain_compare("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
